multi_chan_sched_buffer: RTL and testbench
==========================================

Name: multi_chan_sched_buffer

Overview:
Parametrised successor to the push-button packet input and 4-buffer reader. It assembles bit-serial packets from two active-low key inputs and files each packet into one of NUM_CH circular FIFOs by its channel field. On a periodic tick or a read request, it pops one packet from the channel chosen by an occupancy-weighted score or by fixed priority. It sits between the board key/switch inputs and the display/output logic, and exposes drop, receive and read statistics.

Parameters:
NUM_CH, 4, number of channels; power of 2, >=2; CH_W = clog2(NUM_CH)
DEPTH, 6, entries per channel FIFO, >=2
PAYLOAD_W, 2, payload bits per packet; PKT_W = CH_W + PAYLOAD_W
THRESH, 3, occupancy threshold that switches the score formula
READ_PERIOD, 75000000, clk cycles between automatic read ticks, >=2
CNT_W, 8, width of the statistics counters

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
arm  in  1  level; while high in IDLE, starts packet collection
key0_n  in  1  async button, active low; enters bit 0
key1_n  in  1  async button, active low; enters bit 1
rd_req  in  1  read request; rising edge triggers a read
sched_mode  in  1  0 = score-based, 1 = fixed priority (lowest index first)
out_data  out  1+PKT_W  {valid flag, channel, payload} of last read
out_valid  out  1  one-cycle pulse per successful pop
occupancy  out  NUM_CH*OCC_W  per-channel fill level, channel 0 in LSBs; OCC_W = clog2(DEPTH+1)
collecting  out  1  high in COLLECT
bit_index  out  clog2(PKT_W+1)  bits captured in the current packet
received_cnt, drops_cnt, read_cnt  out  CNT_W each  saturating counters

Behaviour:
- Reset (rst_n=0 at a clk edge): every output is 0; FIFOs are emptied; the tick counter, synchronizers and FSM are cleared; the FSM goes to IDLE. Reset mid-collection discards the partial packet.
- Key path: 2-FF synchronizer, then a falling-edge detect. A bit strobe occurs 3 cycles after the press. If both keys' edges arrive in the same cycle, no bit is taken. Edges in IDLE are ignored.
- FSM IDLE -> COLLECT when arm=1.
- In COLLECT, each strobe shifts the bit in MSB-first and increments bit_index.
- On the PKT_W-th bit, the FSM issues a push the same cycle, returns to IDLE and clears bit_index.
- Push decode: channel = packet[PKT_W-1:PAYLOAD_W], payload = low bits.
  - received_cnt increments on every completed packet.
  - If the target FIFO is full and is not popped in the same cycle, the packet is dropped and drops_cnt increments.
- Occupancy reflects a push on the cycle after the push.
- FIFOs are circular (read/write pointers plus count) with oldest-first pop. Pointers wrap at DEPTH.
- Read event: the tick counter reaches READ_PERIOD-1 (then wraps to 0), or rd_req has a rising edge. Both in the same cycle produce one event.
- Score for channel c with occupancy n:
  - n=0: score 0.
  - n<=THRESH: n*(NUM_CH-c)+(c+1).
  - n>THRESH: n*(c+1)+(NUM_CH-c).
  - Scores are computed combinationally from current occupancy.
  - Highest score wins; a tie goes to the lowest index.
- sched_mode=1 selects the lowest-index non-empty channel.
- On a read event with at least one non-empty channel:
  - Next cycle: out_data = {1, ch, payload}, out_valid=1 for 1 cycle.
  - read_cnt increments and the FIFO pops.
- On a read event with all channels empty: out_data <= 0, no out_valid.
- Simultaneous push and pop on the same channel:
  - Both happen; count is unchanged.
  - A full FIFO accepts the push because the pop frees a slot.
- Counters saturate at 2^CNT_W-1.

Decomposition:
- Package multi_chan_pkg holds:
  - the CH_W, OCC_W and PKT_W derivation functions;
  - the score function (c, n, NUM_CH, THRESH);
  - the sched_mode encodings.
- Sub-module chan_fifo (DEPTH, PAYLOAD_W) provides push, pop, full, empty, count and data; it is instantiated NUM_CH times via generate.
- The key synchronizer and edge detect stay inline.

Test Plan:
- NUM_CH=4, READ_PERIOD=8: arm, keys 0,1,1,0 -> occupancy[1]=1, received_cnt=1; next tick -> out_data=5'b1_01_10, out_valid 1 cycle, read_cnt=1.
- ch0 with 3 entries (score 13), ch3 with 1 entry (score 5) -> read from ch0. Raise both to 4 entries (ch0=8, ch3=17) -> read from ch3.
- sched_mode=1, ch2 and ch3 non-empty -> ch2 read first. Equal scores on ch1 and ch2 in mode 0 -> ch1 read.
- 7 packets to ch2 with no reads -> occupancy[2]=6, drops_cnt=1, received_cnt=7. Full FIFO plus push coinciding with a pop -> accepted, drops_cnt unchanged.
- Both keys pressed together -> bit_index unchanged. rst_n=0 after 2 bits -> bit_index=0, all outputs 0, collecting=0.
- All channels empty at a tick -> out_data=0, out_valid stays 0, read_cnt unchanged. rd_req edge coinciding with a tick -> exactly one pop.

Source files
------------

// File: rtl/multi_chan_pkg.sv
// Shared widths, schedule encodings, FSM states and the channel score for the
// multi-channel scheduled packet buffer.
package multi_chan_pkg;

  localparam logic SCHED_SCORE = 1'b0;
  localparam logic SCHED_PRIO  = 1'b1;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_t;

  function automatic int ch_width(input int num_ch);
    return (num_ch < 2) ? 1 : $clog2(num_ch);
  endfunction

  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int pkt_width(input int num_ch, input int payload_w);
    return ch_width(num_ch) + payload_w;
  endfunction

  // Light load favours low channels; above the threshold high channels win.
  function automatic int score(input int c, input int n, input int num_ch, input int thresh);
    if (n == 0) return 0;
    else if (n <= thresh) return n * (num_ch - c) + (c + 1);
    else return n * (c + 1) + (num_ch - c);
  endfunction

endpackage

// File: rtl/chan_fifo.sv
// Circular per-channel payload FIFO; a pop in the same cycle frees the slot
// a push into a full FIFO needs.
module chan_fifo
  import multi_chan_pkg::*;
#(
  parameter int DEPTH     = 6,
  parameter int PAYLOAD_W = 2,
  localparam int OCC_W    = occ_width(DEPTH),
  localparam int PTR_W    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push_i,
  input  logic                 pop_i,
  input  logic [PAYLOAD_W-1:0] din_i,
  output logic                 full_o,
  output logic                 empty_o,
  output logic [OCC_W-1:0]     count_o,
  output logic [PAYLOAD_W-1:0] dout_o
);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic [PAYLOAD_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]     count_q, count_d;
  logic                 do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == OCC_W'(DEPTH));
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/multi_chan_sched_buffer.sv
// Key-driven packet assembler feeding NUM_CH FIFOs, drained by tick or rd_req.
// state   | meaning
// IDLE    | waiting for arm; key edges ignored
// COLLECT | shifting key bits in MSB-first until a full packet
module multi_chan_sched_buffer
  import multi_chan_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DEPTH       = 6,
  parameter int PAYLOAD_W   = 2,
  parameter int THRESH      = 3,
  parameter int READ_PERIOD = 75000000,
  parameter int CNT_W       = 8,
  localparam int CH_W       = ch_width(NUM_CH),
  localparam int OCC_W      = occ_width(DEPTH),
  localparam int PKT_W      = pkt_width(NUM_CH, PAYLOAD_W),
  localparam int BIDX_W     = $clog2(PKT_W + 1),
  localparam int TICK_W     = $clog2(READ_PERIOD)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    arm,
  input  logic                    key0_n,
  input  logic                    key1_n,
  input  logic                    rd_req,
  input  logic                    sched_mode,
  output logic [PKT_W:0]          out_data,
  output logic                    out_valid,
  output logic [NUM_CH*OCC_W-1:0] occupancy,
  output logic                    collecting,
  output logic [BIDX_W-1:0]       bit_index,
  output logic [CNT_W-1:0]        received_cnt,
  output logic [CNT_W-1:0]        drops_cnt,
  output logic [CNT_W-1:0]        read_cnt
);

  state_t               state_q, state_d;
  logic [2:0]           k0_q, k1_q;
  logic [PKT_W-1:0]     shift_q, shift_d;
  logic [BIDX_W-1:0]    bidx_q, bidx_d;
  logic [TICK_W-1:0]    tick_q;
  logic                 rd_req_q, out_valid_q;
  logic [PKT_W:0]       out_data_q;
  logic [CNT_W-1:0]     rx_q, drop_q, rd_q;
  logic                 fall0, fall1, strobe, push, tick, rd_ev, any, drop;
  logic [CH_W-1:0]      push_ch, sel;
  logic [NUM_CH-1:0]    push_vec, pop_vec, full_vec, empty_vec;
  logic [OCC_W-1:0]     cnt [NUM_CH];
  logic [PAYLOAD_W-1:0] dout [NUM_CH];

  // k*_q[2:1] are the synchronized history; a falling edge is 1 -> 0.
  assign fall0  = k0_q[2] & ~k0_q[1];
  assign fall1  = k1_q[2] & ~k1_q[1];
  assign strobe = fall0 ^ fall1;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bidx_d  = bidx_q;
    push    = 1'b0;
    case (state_q)
      ST_IDLE:    if (arm) state_d = ST_COLLECT;
      ST_COLLECT: if (strobe) begin
        shift_d = {shift_q[PKT_W-2:0], fall1};
        if (bidx_q == BIDX_W'(PKT_W - 1)) begin
          push    = 1'b1;
          bidx_d  = '0;
          state_d = ST_IDLE;
        end else begin
          bidx_d = bidx_q + 1'b1;
        end
      end
      default:    state_d = ST_IDLE;
    endcase
  end

  assign push_ch = shift_d[PKT_W-1:PAYLOAD_W];
  assign tick    = (tick_q == TICK_W'(READ_PERIOD - 1));
  assign rd_ev   = tick | (rd_req & ~rd_req_q);
  assign drop    = push & full_vec[push_ch] & ~pop_vec[push_ch];

  always_comb begin
    int best;
    int sc;
    best = 0;
    sc   = 0;
    any  = 1'b0;
    sel  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      sc = score(c, int'(cnt[c]), NUM_CH, THRESH);
      if (sched_mode == SCHED_PRIO) begin
        if (!any && !empty_vec[c]) begin
          any = 1'b1;
          sel = CH_W'(c);
        end
      end else if (sc > best) begin
        best = sc;
        any  = 1'b1;
        sel  = CH_W'(c);
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign push_vec[g] = push && (push_ch == CH_W'(g));
    assign pop_vec[g]  = rd_ev && any && (sel == CH_W'(g));
    assign occupancy[g*OCC_W +: OCC_W] = cnt[g];

    chan_fifo #(.DEPTH(DEPTH), .PAYLOAD_W(PAYLOAD_W)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push_vec[g]),
      .pop_i   (pop_vec[g]),
      .din_i   (shift_d[PAYLOAD_W-1:0]),
      .full_o  (full_vec[g]),
      .empty_o (empty_vec[g]),
      .count_o (cnt[g]),
      .dout_o  (dout[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      k0_q        <= '0;
      k1_q        <= '0;
      shift_q     <= '0;
      bidx_q      <= '0;
      tick_q      <= '0;
      rd_req_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      rx_q        <= '0;
      drop_q      <= '0;
      rd_q        <= '0;
    end else begin
      state_q     <= state_d;
      k0_q        <= {k0_q[1:0], key0_n};
      k1_q        <= {k1_q[1:0], key1_n};
      shift_q     <= shift_d;
      bidx_q      <= bidx_d;
      tick_q      <= tick ? '0 : tick_q + 1'b1;
      rd_req_q    <= rd_req;
      out_valid_q <= rd_ev & any;
      if (rd_ev) out_data_q <= any ? {1'b1, sel, dout[sel]} : '0;
      if (push && rx_q != '1)              rx_q   <= rx_q + 1'b1;
      if (drop && drop_q != '1)            drop_q <= drop_q + 1'b1;
      if (rd_ev && any && rd_q != '1)      rd_q   <= rd_q + 1'b1;
    end
  end

  assign out_data     = out_data_q;
  assign out_valid    = out_valid_q;
  assign collecting   = (state_q == ST_COLLECT);
  assign bit_index    = bidx_q;
  assign received_cnt = rx_q;
  assign drops_cnt    = drop_q;
  assign read_cnt     = rd_q;

endmodule

// File: tb/tb_multi_chan_sched_buffer.sv
// Directed bench: a fast-tick instance for periodic reads and a slow-tick
// instance driven by rd_req for scheduling, drop and reset behaviour.
module tb_multi_chan_sched_buffer;

  logic clk = 1'b0;
  logic rst_n = 1'b0, arm = 1'b0, key0_n = 1'b1, key1_n = 1'b1;
  logic rd_req = 1'b0, sched_mode = 1'b0;

  logic [4:0]  f_data, s_data;
  logic        f_valid, s_valid, f_coll, s_coll;
  logic [11:0] f_occ, s_occ;
  logic [2:0]  f_bidx, s_bidx;
  logic [7:0]  f_rx, f_drop, f_rd, s_rx, s_drop, s_rd;
  logic [2:0]  tph;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Phase of the fast instance's 8-cycle read tick, used only to align stimulus.
  always @(posedge clk) begin
    if (!rst_n) tph <= 3'd0;
    else        tph <= tph + 3'd1;
  end

  multi_chan_sched_buffer #(.NUM_CH(4), .DEPTH(6), .PAYLOAD_W(2), .THRESH(3),
                            .READ_PERIOD(8), .CNT_W(8)) u_fast (
    .clk(clk), .rst_n(rst_n), .arm(arm), .key0_n(key0_n), .key1_n(key1_n),
    .rd_req(rd_req), .sched_mode(sched_mode), .out_data(f_data), .out_valid(f_valid),
    .occupancy(f_occ), .collecting(f_coll), .bit_index(f_bidx),
    .received_cnt(f_rx), .drops_cnt(f_drop), .read_cnt(f_rd));

  multi_chan_sched_buffer #(.NUM_CH(4), .DEPTH(6), .PAYLOAD_W(2), .THRESH(3),
                            .READ_PERIOD(100000), .CNT_W(8)) u_slow (
    .clk(clk), .rst_n(rst_n), .arm(arm), .key0_n(key0_n), .key1_n(key1_n),
    .rd_req(rd_req), .sched_mode(sched_mode), .out_data(s_data), .out_valid(s_valid),
    .occupancy(s_occ), .collecting(s_coll), .bit_index(s_bidx),
    .received_cnt(s_rx), .drops_cnt(s_drop), .read_cnt(s_rd));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Bit is taken on the third edge after the press, so the task returns just after it.
  task automatic press(input logic b);
    if (b) key1_n = 1'b0;
    else   key0_n = 1'b0;
    cyc(1);
    key0_n = 1'b1;
    key1_n = 1'b1;
    cyc(2);
  endtask

  task automatic send_pkt(input int ch, input int pl, input bit rd_at_push);
    logic [3:0] pkt;
    pkt = {ch[1:0], pl[1:0]};
    arm = 1'b1;
    cyc(1);
    arm = 1'b0;
    for (int i = 3; i >= 1; i--) press(pkt[i]);
    if (pkt[0]) key1_n = 1'b0;
    else        key0_n = 1'b0;
    cyc(1);
    key0_n = 1'b1;
    key1_n = 1'b1;
    cyc(1);
    if (rd_at_push) rd_req = 1'b1;
    cyc(1);
    rd_req = 1'b0;
  endtask

  task automatic rd_pulse();
    rd_req = 1'b0;
    cyc(1);
    rd_req = 1'b1;
    cyc(1);
    rd_req = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int guard;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_data", s_data, 5'd0);
    chk("rst_occ", s_occ, 12'd0);
    chk("rst_collecting", s_coll, 1'b0);
    rst_n = 1'b1;
    cyc(1);

    // Keys 0,1,1,0 -> channel 1, payload 2'b10
    send_pkt(1, 2, 1'b0);
    chk("fast_occ_ch1", f_occ[5:3], 3'd1);
    chk("fast_rx", f_rx, 8'd1);
    chk("slow_rx", s_rx, 8'd1);
    for (int i = 0; i < 10 && !f_valid; i++) cyc(1);
    chk("fast_tick_valid", f_valid, 1'b1);
    chk("fast_tick_data", f_data, 5'b1_01_10);
    cyc(1);
    chk("fast_valid_one_cycle", f_valid, 1'b0);
    chk("fast_read_cnt", f_rd, 8'd1);
    rd_pulse();
    chk("slow_rd_valid", s_valid, 1'b1);
    chk("slow_rd_data", s_data, 5'b1_01_10);
    chk("slow_rd_occ", s_occ, 12'd0);

    // Score: ch0 n=3 -> 13 beats ch3 n=1 -> 5
    send_pkt(0, 1, 1'b0);
    send_pkt(0, 2, 1'b0);
    send_pkt(0, 3, 1'b0);
    send_pkt(3, 3, 1'b0);
    chk("score_occ_a", s_occ, 12'b001_000_000_011);
    rd_pulse();
    chk("score_low_load", s_data, 5'b1_00_01);
    // ch0 n=4 -> 8, ch3 n=4 -> 17
    send_pkt(0, 0, 1'b0);
    send_pkt(0, 1, 1'b0);
    send_pkt(3, 0, 1'b0);
    send_pkt(3, 1, 1'b0);
    send_pkt(3, 2, 1'b0);
    chk("score_occ_b", s_occ, 12'b100_000_000_100);
    rd_pulse();
    chk("score_high_load", s_data, 5'b1_11_11);
    for (int i = 0; i < 7; i++) rd_pulse();
    chk("drain_occ", s_occ, 12'd0);
    chk("drain_rd_cnt", s_rd, 8'd10);

    // Fixed priority, then equal-score tie in score mode
    send_pkt(3, 0, 1'b0);
    send_pkt(2, 1, 1'b0);
    sched_mode = 1'b1;
    rd_pulse();
    chk("prio_first", s_data, 5'b1_10_01);
    rd_pulse();
    chk("prio_second", s_data, 5'b1_11_00);
    sched_mode = 1'b0;
    send_pkt(2, 3, 1'b0);
    send_pkt(1, 2, 1'b0);
    rd_pulse();
    chk("tie_low_index", s_data, 5'b1_01_10);
    rd_pulse();
    chk("tie_second", s_data, 5'b1_10_11);
    chk("tie_rd_cnt", s_rd, 8'd14);

    // Overfill ch2, then push into full FIFO while it is popped
    for (int i = 0; i < 7; i++) send_pkt(2, i % 4, 1'b0);
    chk("full_occ", s_occ, 12'b000_110_000_000);
    chk("full_drops", s_drop, 8'd1);
    chk("full_rx", s_rx, 8'd21);
    send_pkt(2, 3, 1'b1);
    chk("pushpop_valid", s_valid, 1'b1);
    chk("pushpop_data", s_data, 5'b1_10_00);
    chk("pushpop_occ", s_occ, 12'b000_110_000_000);
    chk("pushpop_drops", s_drop, 8'd1);
    chk("pushpop_rx", s_rx, 8'd22);
    for (int i = 0; i < 6; i++) rd_pulse();
    chk("wrap_last_data", s_data, 5'b1_10_11);
    chk("wrap_occ", s_occ, 12'd0);
    chk("wrap_rd_cnt", s_rd, 8'd21);

    // Simultaneous keys, then reset mid-packet
    arm = 1'b1;
    cyc(1);
    arm = 1'b0;
    chk("collecting_high", s_coll, 1'b1);
    key0_n = 1'b0;
    key1_n = 1'b0;
    cyc(1);
    key0_n = 1'b1;
    key1_n = 1'b1;
    cyc(3);
    chk("both_keys_bidx", s_bidx, 3'd0);
    press(1'b0);
    press(1'b1);
    chk("two_bits_bidx", s_bidx, 3'd2);
    chk("two_bits_bidx_fast", f_bidx, 3'd2);
    rst_n = 1'b0;
    cyc(1);
    chk("midrst_bidx", s_bidx, 3'd0);
    chk("midrst_coll", s_coll, 1'b0);
    chk("midrst_data", s_data, 5'd0);
    chk("midrst_valid", s_valid, 1'b0);
    chk("midrst_cnts", {s_rx, s_drop, s_rd}, 24'd0);
    chk("midrst_fast_cnts", {f_rx, f_rd}, 16'd0);
    rst_n = 1'b1;
    cyc(1);

    // Fresh packet after reset, then an empty tick clears fast out_data
    send_pkt(1, 1, 1'b0);
    chk("post_rst_occ", s_occ, 12'b000_000_001_000);
    for (int i = 0; i < 10 && !f_valid; i++) cyc(1);
    chk("fast_post_rst_data", f_data, 5'b1_01_01);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      if (f_valid) pulses++;
    end
    chk("empty_tick_no_valid", pulses, 0);
    chk("empty_tick_data", f_data, 5'd0);
    chk("empty_tick_rd_cnt", f_rd, 8'd1);
    rd_pulse();
    chk("slow_post_rst_data", s_data, 5'b1_01_01);

    // rd_req rising edge on the same cycle as the fast tick
    guard = 0;
    while (tph != 3'd2 && guard < 16) begin
      cyc(1);
      guard++;
    end
    chk("tick_align", tph, 3'd2);
    send_pkt(0, 2, 1'b0);
    chk("coinc_occ_before", f_occ[2:0], 3'd1);
    rd_req = 1'b1;
    cyc(1);
    rd_req = 1'b0;
    chk("coinc_valid", f_valid, 1'b1);
    chk("coinc_data", f_data, 5'b1_00_10);
    chk("coinc_rd_cnt", f_rd, 8'd2);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      if (f_valid) pulses++;
    end
    chk("coinc_single_pop", pulses, 0);
    chk("coinc_rd_cnt_after", f_rd, 8'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
